mem_nr_1w_sync: RTL and testbench

MEM_NR_1W_SYNC -- requirements
Module: mem_nr_1w_sync

---
 rtl/mem_nr_1w_pkg.sv | 22 ++
 rtl/mem_rd_port.sv | 77 +++++++
 rtl/mem_nr_1w_sync.sv | 166 ++++++++++++++++
 tb/tb_mem_nr_1w_sync.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_nr_1w_pkg.sv
// -----------------------------------------------------------------------------
// mem_nr_1w_pkg
// Shared definitions for the N-read / 1-write synchronous memory:
//   - state_t     : controller states (CLEAR sweep after reset, RUN for service)
//   - DEF_*       : default parameter values used by mem_nr_1w_sync
// Configuration macro MEM_NR_1W_BYPASS_EN (see mem_nr_1w_sync / mem_rd_port).
// -----------------------------------------------------------------------------
package mem_nr_1w_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ADDR_BITS = 4;
    localparam int DEF_NUM_RD    = 2;

    localparam int MIN_NUM_RD    = 1;
    localparam int MAX_NUM_RD    = 8;

endpackage : mem_nr_1w_pkg

// File: rtl/mem_rd_port.sv
// -----------------------------------------------------------------------------
// mem_rd_port
// One registered read port of mem_nr_1w_sync. Captures the addressed memory
// word one cycle after a request and raises a one-cycle valid strobe.
//
// Configuration:
//   MEM_NR_1W_BYPASS_EN defined   : a same-cycle write to the read address
//                                   forwards the write data (write-first).
//   MEM_NR_1W_BYPASS_EN undefined : the pre-write contents are returned
//                                   (read-before-write).
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   i_en        in   read request, already qualified by the controller
//   i_addr      in   read address
//   i_mem_data  in   combinational array output at i_addr
//   i_wr_en     in   qualified write enable of the array
//   i_wr_addr   in   write address of the array
//   i_wr_data   in   write data of the array
//   o_data      out  registered read data, held while no request
//   o_valid     out  one-cycle strobe marking new o_data
// -----------------------------------------------------------------------------
module mem_rd_port #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [WIDTH-1:0]     i_mem_data,
    input  logic                 i_wr_en,
    input  logic [ADDR_BITS-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]     i_wr_data,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_valid
);

    logic [WIDTH-1:0] w_data_next;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

`ifdef MEM_NR_1W_BYPASS_EN
    always_comb begin
        w_data_next = i_mem_data;
        if (i_wr_en && (i_wr_addr == i_addr)) begin
            w_data_next = i_wr_data;
        end
    end
`else
    // The array is read before the clock edge commits the write, so the
    // old word is returned on a collision without any extra logic.
    logic w_unused_wr;
    assign w_unused_wr = ^{i_wr_en, i_wr_addr, i_wr_data};

    always_comb begin
        w_data_next = i_mem_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_en;
            if (i_en) begin
                r_data <= w_data_next;
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule : mem_rd_port

// File: rtl/mem_nr_1w_sync.sv
// -----------------------------------------------------------------------------
// mem_nr_1w_sync
// Synchronous memory with NUM_RD registered read ports and one write port.
// After reset a CLEAR sweep writes zero to every word (busy high, requests
// ignored); afterwards the block serves reads (latency 1) and writes.
//
// Configuration macro:
//   MEM_NR_1W_BYPASS_EN : same-cycle read of the written address returns the
//                         new data; undefined returns the old data.
//
// Parameters:
//   WIDTH      data word width
//   ADDR_BITS  address width, depth = 2**ADDR_BITS
//   NUM_RD     number of read ports, 1..8
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   rd_en     in   [NUM_RD]            per-port read request
//   rd_addr   in   [NUM_RD*ADDR_BITS]  flattened read addresses
//   rd_data   out  [NUM_RD*WIDTH]      flattened registered read data
//   rd_valid  out  [NUM_RD]            per-port new-data strobe
//   wr_en     in   write request
//   wr_addr   in   [ADDR_BITS]         write address
//   wr_data   in   [WIDTH]             write data
//   busy      out  high while the clear sweep runs
// -----------------------------------------------------------------------------
module mem_nr_1w_sync
    import mem_nr_1w_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int NUM_RD    = DEF_NUM_RD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD-1:0]           rd_en,
    input  logic [NUM_RD*ADDR_BITS-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]     rd_data,
    output logic [NUM_RD-1:0]           rd_valid,
    input  logic                        wr_en,
    input  logic [ADDR_BITS-1:0]        wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    output logic                        busy
);

    localparam int                   DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    if ((NUM_RD < MIN_NUM_RD) || (NUM_RD > MAX_NUM_RD)) begin : g_bad_num_rd
        $error("mem_nr_1w_sync: NUM_RD out of range 1..8");
    end

    // -------------------------------------------------------------------------
    // Controller: CLEAR sweep then RUN
    // -------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic [ADDR_BITS-1:0] r_clr_addr;
    logic [ADDR_BITS-1:0] w_clr_addr_next;
    logic                 w_busy;
    logic                 w_run;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_clr_addr <= w_clr_addr_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        w_busy          = 1'b0;
        w_run           = 1'b0;
        case (r_state)
            CLEAR: begin
                w_busy = 1'b1;
                // Hold the counter at the last address on exit; it only
                // returns to zero through reset.
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_next = RUN;
                end else begin
                    w_clr_addr_next = r_clr_addr + 1'b1;
                end
            end
            RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    assign busy = w_busy | rst;

    // -------------------------------------------------------------------------
    // Storage and single write port
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic                 w_mem_we;
    logic [ADDR_BITS-1:0] w_mem_waddr;
    logic [WIDTH-1:0]     w_mem_wdata;
    logic                 w_user_we;

    assign w_user_we = w_run & wr_en & ~rst;

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = wr_addr;
        w_mem_wdata = wr_data;
        if (rst) begin
            w_mem_we = 1'b0;
        end else if (w_busy) begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_clr_addr;
            w_mem_wdata = '0;
        end else begin
            w_mem_we = w_user_we;
        end
    end

    // NOTE: the array has no reset term; it stays a plain RAM and is zeroed
    // by the CLEAR sweep instead.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        logic [ADDR_BITS-1:0] w_addr;
        logic [WIDTH-1:0]     w_mem_data;

        assign w_addr     = rd_addr[gi*ADDR_BITS +: ADDR_BITS];
        assign w_mem_data = r_mem[w_addr];

        mem_rd_port #(
            .WIDTH     (WIDTH),
            .ADDR_BITS (ADDR_BITS)
        ) u_rd_port (
            .clk        (clk),
            .rst        (rst),
            .i_en       (rd_en[gi] & w_run),
            .i_addr     (w_addr),
            .i_mem_data (w_mem_data),
            .i_wr_en    (w_user_we),
            .i_wr_addr  (wr_addr),
            .i_wr_data  (wr_data),
            .o_data     (rd_data[gi*WIDTH +: WIDTH]),
            .o_valid    (rd_valid[gi])
        );
    end

endmodule : mem_nr_1w_sync

// File: tb/tb_mem_nr_1w_sync.sv
// -----------------------------------------------------------------------------
// tb_mem_nr_1w_sync
// Directed bench for mem_nr_1w_sync: a default instance (WIDTH=8, NUM_RD=2)
// and a wide instance (WIDTH=16, NUM_RD=4) sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_mem_nr_1w_sync;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Default instance
    logic [1:0]  rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic [1:0]  rd_valid;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    mem_nr_1w_sync dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    // Wide instance
    logic [3:0]  rd_en4;
    logic [15:0] rd_addr4;
    logic [63:0] rd_data4;
    logic [3:0]  rd_valid4;
    logic        wr_en4;
    logic [3:0]  wr_addr4;
    logic [15:0] wr_data4;
    logic        busy4;

    mem_nr_1w_sync #(.WIDTH(16), .ADDR_BITS(4), .NUM_RD(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en4),
        .rd_addr  (rd_addr4),
        .rd_data  (rd_data4),
        .rd_valid (rd_valid4),
        .wr_en    (wr_en4),
        .wr_addr  (wr_addr4),
        .wr_data  (wr_data4),
        .busy     (busy4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles with busy high starting now; also injects requests that
    // must be ignored and records any rd_valid seen on the default instance.
    task automatic sweep(output int cnt, output logic saw_valid);
        cnt       = 0;
        saw_valid = 1'b0;
        rd_en     = 2'b11;
        rd_addr   = {4'd1, 4'd5};
        while (busy === 1'b1 && cnt < 100) begin
            if (rd_valid !== 2'b00) saw_valid = 1'b1;
            wr_en = 1'b0;
            if (cnt == 2) begin
                wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hFF;
            end else if (cnt == 15) begin
                wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h77;
            end
            cnt++;
            step();
        end
        if (rd_valid !== 2'b00) saw_valid = 1'b1;
        wr_en = 1'b0;
        rd_en = 2'b00;
    endtask

    task automatic write(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    int   cnt;
    logic saw_valid;
    logic [7:0] exp_collide;

    initial begin
        rst = 1'b1;
        rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en4 = '0; rd_addr4 = '0; wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0;
        step();
        step();

        // Reset state
        check("rst_busy",     busy,      1);
        check("rst_rd_valid", rd_valid,  0);
        check("rst_rd_data",  rd_data,   0);
        check("rst_rd_data4", rd_data4,  0);

        // Sweep length and ignored requests during CLEAR
        rst = 1'b0;
        sweep(cnt, saw_valid);
        check("sweep_cycles",   cnt,       16);
        check("sweep_no_valid", saw_valid, 0);
        check("busy_low",       busy,      0);
        check("busy4_low",      busy4,     0);

        // Every word reads zero after the sweep (port1 walks downwards)
        for (int a = 0; a < 16; a++) begin
            rd_en   = 2'b11;
            rd_addr = {4'(15 - a), 4'(a)};
            step();
            check($sformatf("clear_rd_%0d", a), {rd_valid, rd_data}, {2'b11, 16'h0000});
        end
        rd_en = 2'b00;
        step();
        check("idle_valid", rd_valid, 2'b00);

        // Write then dual read of the same address
        write(4'd3, 8'hA5);
        rd_en = 2'b11; rd_addr = {4'd3, 4'd3};
        step();
        rd_en = 2'b00;
        check("dual_valid", rd_valid, 2'b11);
        check("dual_data",  rd_data,  16'hA5A5);
        step();
        check("hold_valid", rd_valid, 2'b00);
        check("hold_data",  rd_data,  16'hA5A5);

        // Read/write collision on addr 7
        write(4'd7, 8'h11);
`ifdef MEM_NR_1W_BYPASS_EN
        exp_collide = 8'h22;
`else
        exp_collide = 8'h11;
`endif
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 8'h22;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd7};
        step();
        wr_en = 1'b0;
        check("collide_valid", rd_valid,      2'b01);
        check("collide_data",  rd_data[7:0],  exp_collide);
        check("collide_p1",    rd_data[15:8], 8'hA5);
        step();
        rd_en = 2'b00;
        check("after_collide", rd_data[7:0], 8'h22);

        // Boundary addresses on crossed ports
        write(4'd15, 8'hF0);
        write(4'd0,  8'h0F);
        rd_en = 2'b11; rd_addr = {4'd0, 4'd15};
        step();
        rd_en = 2'b00;
        check("edge_addrs", rd_data, 16'h0FF0);

        // Wide instance: partial enables keep the other ports' data
        for (int a = 0; a < 4; a++) begin
            wr_en4 = 1'b1; wr_addr4 = 4'(a); wr_data4 = 16'h1000 + 16'(a);
            step();
        end
        wr_en4 = 1'b0;
        rd_en4 = 4'b0101; rd_addr4 = {4'd0, 4'd1, 4'd2, 4'd3};
        step();
        check("w4_pre", rd_data4, {16'h0000, 16'h1001, 16'h0000, 16'h1003});
        rd_en4 = 4'b1010; rd_addr4 = {4'd3, 4'd2, 4'd1, 4'd0};
        step();
        rd_en4 = 4'b0000;
        check("w4_valid", rd_valid4, 4'b1010);
        check("w4_data",  rd_data4, {16'h1003, 16'h1001, 16'h1001, 16'h1003});

        // Reset pulse in RUN restarts the sweep and clears contents
        write(4'd9, 8'h3C);
        rd_en = 2'b01; rd_addr = {4'd0, 4'd9};
        step();
        rd_en = 2'b00;
        check("pre_rst_9", rd_data[7:0], 8'h3C);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_data",  rd_data, 0);
        check("rst2_valid", rd_valid, 0);
        sweep(cnt, saw_valid);
        check("sweep2_cycles",   cnt,       16);
        check("sweep2_no_valid", saw_valid, 0);
        rd_en = 2'b11; rd_addr = {4'd1, 4'd9};
        step();
        rd_en = 2'b00;
        check("rst2_addr9_1", rd_data, 16'h0000);
        rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
        step();
        rd_en = 2'b00;
        check("rst2_addr5", {rd_valid, rd_data[7:0]}, {2'b01, 8'h00});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop in case a wait is never satisfied
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_mem_nr_1w_sync
